// File: rtl/sample_fifo_serial_tx_if.sv
// sample_fifo_serial_tx_if: parallel sample input, 1-bit serial output and FIFO status
interface sample_fifo_serial_tx_if #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
);
  logic [DATA_WIDTH-1:0]         iv_din;
  logic                          i_din_valid;
  logic                          o_ready;
  logic                          o_dout;
  logic                          o_dout_valid;
  logic                          i_ready;
  logic [$clog2(FIFO_DEPTH):0]   ov_fifo_count;
  logic                          o_busy;
  modport slave (
    input  iv_din, i_din_valid, i_ready,
    output o_ready, o_dout, o_dout_valid, ov_fifo_count, o_busy
  );
  modport master (
    output iv_din, i_din_valid, i_ready,
    input  o_ready, o_dout, o_dout_valid, ov_fifo_count, o_busy
  );
endinterface

// File: rtl/sample_fifo_serial_tx.sv
// sample_fifo_serial_tx: buffers parallel samples in a FIFO and shifts them out MSB-first on a 1-bit valid/ready link
module sample_fifo_serial_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  sample_fifo_serial_tx_if.slave    bus
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int BW   = $clog2(DATA_WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  live_q;
  logic                  rdy, push, xfer, last, pop;
  // live_q keeps o_ready low until the first edge after reset release
  assign rdy = i_en & live_q & (cnt_q != CNTW'(FIFO_DEPTH));
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      live_q  <= 1'b1;
    end
  always_ff @(posedge i_clk)
    if (push) mem_q[wr_q] <= bus.iv_din;
  // pop uses the pre-push count, so a last-bit reload never sees a same-edge push
  always_comb begin
    push    = rdy & bus.i_din_valid;
    xfer    = i_en & (state_q == SHIFT) & bus.i_ready;
    last    = xfer & (bit_q == '0);
    pop     = i_en & (cnt_q != '0) & ((state_q == IDLE) | last);
    wr_d    = wr_q + AW'(push);
    rd_d    = rd_q + AW'(pop);
    cnt_d   = cnt_q + CNTW'(push) - CNTW'(pop);
    state_d = pop ? SHIFT : last ? IDLE : state_q;
    sh_d    = pop ? mem_q[rd_q] : xfer ? {sh_q[DATA_WIDTH-2:0], 1'b0} : sh_q;
    bit_d   = pop ? BW'(DATA_WIDTH - 1) : xfer ? bit_q - 1'b1 : bit_q;
  end
  always_comb begin
    bus.o_ready       = rdy;
    bus.o_dout        = sh_q[DATA_WIDTH-1];
    bus.o_dout_valid  = i_en & (state_q == SHIFT);
    bus.o_busy        = state_q == SHIFT;
    bus.ov_fifo_count = cnt_q;
  end
endmodule

// File: tb/tb_sample_fifo_serial_tx.sv
// tb_sample_fifo_serial_tx: scenario tasks plus a serial receiver that rebuilds words against a scoreboard
module tb_sample_fifo_serial_tx;
  localparam int W = 24;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0;
  sample_fifo_serial_tx_if bus();
  sample_fifo_serial_tx dut (.i_clk(clk), .i_rst(rst), .i_en(en), .bus(bus));
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] rx_word = '0, rx_exp;
  int rx_bits = 0;
  // receiver: a bit counts when valid, ready and enable are all high at the coming edge
  always @(negedge clk)
    if (rst && en && bus.o_dout_valid && bus.i_ready) begin
      rx_word = {rx_word[W-2:0], bus.o_dout};
      rx_bits++;
      if (rx_bits == W) begin
        rx_bits = 0;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rx_word: got %h, none expected", rx_word);
        end else begin
          rx_exp = exp_q.pop_front();
          if (rx_word !== rx_exp) begin
            miscompares++;
            $display("FAIL rx_word: got %h, expected %h", rx_word, rx_exp);
          end
        end
      end
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [W-1:0] w, output bit acc);
    bus.iv_din = w;
    bus.i_din_valid = 1'b1;
    @(negedge clk);
    acc = bus.o_ready;
    step();
    bus.i_din_valid = 1'b0;
    if (acc) exp_q.push_back(w);
  endtask
  task automatic wait_idle(input bit rnd);
    int n = 0;
    while ((bus.o_busy || bus.ov_fifo_count != 0 || exp_q.size() != 0) && n < 2000) begin
      if (rnd) bus.i_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    bus.i_ready = 1'b1;
    vectors += 2;
    if (n >= 2000) begin miscompares++; $display("FAIL drain_timeout: %0d words left, limit 2000 cycles", exp_q.size()); end
    if (rx_bits !== 0) begin miscompares++; $display("FAIL rx_partial: %0d stray bits, expected 0", rx_bits); end
  endtask
  task automatic test_reset();
    en = 1'b1;
    step();
    vectors++;
    if ({bus.o_ready, bus.o_dout_valid, bus.o_busy, bus.o_dout, bus.ov_fifo_count} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: rdy=%b v=%b busy=%b d=%b cnt=%0d, expected all 0",
               bus.o_ready, bus.o_dout_valid, bus.o_busy, bus.o_dout, bus.ov_fifo_count);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.o_ready !== 1'b0) begin miscompares++; $display("FAIL ready_before_edge: got %b, expected 0", bus.o_ready); end
    step();
    vectors++;
    if (bus.o_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_edge: got %b, expected 1", bus.o_ready); end
  endtask
  task automatic test_single();
    logic [W-1:0] w = 24'hA5C3F0;
    bit acc;
    bus.i_ready = 1'b1;
    push(w, acc);
    vectors++;
    if ({acc, bus.o_dout_valid, bus.ov_fifo_count} !== {1'b1, 1'b0, 3'd1}) begin
      miscompares++;
      $display("FAIL single_push: acc=%b v=%b cnt=%0d, expected 1 0 1", acc, bus.o_dout_valid, bus.ov_fifo_count);
    end
    step();
    for (int i = 0; i < W; i++) begin
      vectors++;
      if ({bus.o_dout_valid, bus.o_dout} !== {1'b1, w[W-1-i]}) begin
        miscompares++;
        $display("FAIL single_bit%0d: v=%b d=%b, expected v=1 d=%b", i, bus.o_dout_valid, bus.o_dout, w[W-1-i]);
      end
      step();
    end
    vectors++;
    if ({bus.o_dout_valid, bus.o_busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL single_end: v=%b busy=%b, expected 0 0", bus.o_dout_valid, bus.o_busy);
    end
  endtask
  task automatic test_back_to_back();
    bit acc;
    int acc_n = 0, gaps = 0;
    bus.i_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push({4'(i + 1), 20'h5A5A5}, acc);
      acc_n += int'(acc);
    end
    vectors++;
    if ({acc_n, bus.o_ready, bus.ov_fifo_count} !== {32'd5, 1'b0, 3'd4}) begin
      miscompares++;
      $display("FAIL b2b_fill: accepted=%0d rdy=%b cnt=%0d, expected 5 0 4", acc_n, bus.o_ready, bus.ov_fifo_count);
    end
    bus.i_ready = 1'b1;
    for (int i = 0; i < 5 * W; i++) begin
      if (bus.o_dout_valid !== 1'b1) gaps++;
      step();
    end
    vectors += 2;
    if (gaps !== 0) begin miscompares++; $display("FAIL b2b_gaps: got %0d idle cycles, expected 0", gaps); end
    if (bus.o_dout_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_end_valid: got %b, expected 0", bus.o_dout_valid); end
    wait_idle(1'b0);
  endtask
  task automatic test_random_ready();
    bit acc;
    bus.i_ready = 1'b0;
    push(24'h000001, acc);
    push(24'h800000, acc);
    push(24'hFFFFFF, acc);
    wait_idle(1'b1);
  endtask
  task automatic test_enable_pause();
    logic [W-1:0] w = 24'h123456;
    bit acc;
    logic [2:0] cnt0;
    bus.i_ready = 1'b1;
    push(w, acc);
    step();
    repeat (10) step();
    en = 1'b0;
    #1;
    cnt0 = bus.ov_fifo_count;
    vectors++;
    if ({bus.o_dout_valid, bus.o_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL pause_outputs: v=%b rdy=%b, expected 0 0", bus.o_dout_valid, bus.o_ready);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if ({bus.o_dout_valid, bus.o_busy, bus.o_dout, bus.ov_fifo_count} !== {1'b0, 1'b1, w[W-11], cnt0}) begin
        miscompares++;
        $display("FAIL pause_frozen%0d: v=%b busy=%b d=%b cnt=%0d, expected 0 1 %b %0d",
                 i, bus.o_dout_valid, bus.o_busy, bus.o_dout, bus.ov_fifo_count, w[W-11], cnt0);
      end
    end
    en = 1'b1;
    #1;
    vectors++;
    if ({bus.o_dout_valid, bus.o_dout} !== {1'b1, w[W-11]}) begin
      miscompares++;
      $display("FAIL pause_resume: v=%b d=%b, expected 1 %b", bus.o_dout_valid, bus.o_dout, w[W-11]);
    end
    wait_idle(1'b0);
  endtask
  task automatic test_full_simul();
    bit acc;
    bus.i_ready = 1'b0;
    for (int i = 0; i < 5; i++) push({8'hC0 + 8'(i), 16'h1234}, acc);
    bus.i_ready = 1'b1;
    repeat (W - 1) step();
    push(24'hDEAD00, acc);
    vectors++;
    if ({acc, bus.ov_fifo_count, bus.o_dout_valid} !== {1'b0, 3'd3, 1'b1}) begin
      miscompares++;
      $display("FAIL full_pop_push: acc=%b cnt=%0d v=%b, expected 0 3 1", acc, bus.ov_fifo_count, bus.o_dout_valid);
    end
    repeat (W - 1) step();
    push(24'h0FACE0, acc);
    vectors++;
    if ({acc, bus.ov_fifo_count, bus.o_dout_valid, bus.o_dout} !== {1'b1, 3'd3, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL reload_push: acc=%b cnt=%0d v=%b d=%b, expected 1 3 1 1",
               acc, bus.ov_fifo_count, bus.o_dout_valid, bus.o_dout);
    end
    wait_idle(1'b0);
  endtask
  task automatic test_async_reset();
    bit acc;
    bus.i_ready = 1'b0;
    for (int i = 0; i < 4; i++) push({4'hE, 4'(i), 16'hFFFF}, acc);
    vectors++;
    if (bus.ov_fifo_count !== 3'd3) begin miscompares++; $display("FAIL areset_fill: cnt=%0d, expected 3", bus.ov_fifo_count); end
    bus.i_ready = 1'b1;
    repeat (7) step();
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({bus.o_dout_valid, bus.ov_fifo_count, bus.o_busy, bus.o_ready, bus.o_dout} !== 7'b0) begin
      miscompares++;
      $display("FAIL areset_immediate: v=%b cnt=%0d busy=%b rdy=%b d=%b, expected all 0",
               bus.o_dout_valid, bus.ov_fifo_count, bus.o_busy, bus.o_ready, bus.o_dout);
    end
    exp_q.delete();
    rx_bits = 0;
    step();
    step();
    #2 rst = 1'b1;
    step();
    push(24'h5A0F3C, acc);
    vectors++;
    if (acc !== 1'b1) begin miscompares++; $display("FAIL areset_push: acc=%b, expected 1", acc); end
    wait_idle(1'b0);
  endtask
  initial begin
    bus.iv_din = '0;
    bus.i_din_valid = 1'b0;
    bus.i_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_random_ready();
    test_enable_pause();
    test_full_simul();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sample_fifo_serial_tx.md
Name: sample_fifo_serial_tx

Overview:
- Host-side transmitter that drives the FIR chain's 1-bit serial input link.
- Accepts parallel samples on a valid/ready port and buffers them in a small FIFO.
- Shifts each sample out MSB-first as DATA_WIDTH consecutive bit transfers on a 1-bit valid/ready link.
- Produces exactly the framing the chain's input deserializer consumes, and is used as the stimulus source in system benches.

Parameters:
DATA_WIDTH, 24, sample width in bits; also the number of bit transfers per word.
FIFO_DEPTH, 4, number of buffered samples; power of 2, >= 2.

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  reset, asynchronous, active-low (0 = reset).
i_en  in  1  global enable; 0 freezes all state.
iv_din  in  DATA_WIDTH  parallel sample.
i_din_valid  in  1  iv_din valid.
o_ready  out  1  FIFO can accept a sample this cycle.
o_dout  out  1  serial bit, MSB first.
o_dout_valid  out  1  o_dout valid.
i_ready  in  1  downstream accepts the current bit.
ov_fifo_count  out  clog2(FIFO_DEPTH)+1  samples held in the FIFO, excluding the word in the shifter.
o_busy  out  1  shifter holds a word being transmitted.

Behaviour:
- Reset (i_rst=0, asynchronous):
  - FIFO empty; read and write pointers 0; ov_fifo_count=0.
  - FSM=IDLE; bit counter 0; shift register 0.
  - o_dout=0, o_dout_valid=0, o_busy=0, o_ready=0 while reset is held.
  - o_ready goes to 1 on the first edge after reset release.
  - Reset mid-word discards the partial word and all FIFO contents; there is no resume.
- Handshakes:
  - A sample is pushed on a rising edge when i_en & i_din_valid & o_ready.
  - A bit transfers on a rising edge when i_en & o_dout_valid & i_ready.
- o_ready = i_en & (ov_fifo_count != FIFO_DEPTH). When full, a push is refused even if a pop occurs on the same edge.
- The FIFO is a registered circular buffer. Pointers wrap modulo FIFO_DEPTH. Count is +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- FSM states:
  - IDLE: o_dout_valid=0. If i_en and the FIFO is non-empty: pop the head into the shift register, bit counter=DATA_WIDTH-1, go to SHIFT.
  - SHIFT: o_dout_valid=i_en; o_dout=shift_reg[DATA_WIDTH-1]. On each bit transfer: shift left by one, decrement the counter.
  - Last bit in SHIFT (counter=0 and the bit transfers):
    - If the FIFO is non-empty (count before any same-edge push), pop the next word and reload on that edge; stay in SHIFT with no bubble cycle.
    - Otherwise go to IDLE.
- A word pushed into an empty FIFO while the FSM is IDLE is pushed at edge k, popped at edge k+1, and its MSB is valid after edge k+1. The FIFO is never bypassed.
- i_ready low holds o_dout and o_dout_valid stable. Bits are never dropped or repeated.
- i_en=0: no push, pop, shift or count change; o_dout_valid=0 and o_ready=0. The partial word resumes exactly where it stopped when i_en returns to 1.
- o_busy=1 in SHIFT, 0 in IDLE.
- Throughput: a continuous stream gives 1 bit per cycle when i_ready=1.
- Implementation: single always block for the FSM plus FIFO logic; no combinational path from i_ready to o_ready.

Test Plan:
- Reset, i_en=1, push 24'hA5C3F0, i_ready=1 -> o_dout_valid rises one cycle after the push edge. Serial bits are 1,0,1,0,0,1,0,1,... (MSB first) for exactly 24 cycles, then o_dout_valid=0 and o_busy=0.
- Push 6 words back-to-back with i_ready=0 -> 5 accepted (1 in shifter + 4 in FIFO); o_ready=0 and ov_fifo_count=4. Release i_ready -> 120 consecutive valid bits with no gap, and data is word-ordered.
- i_ready toggled 1/0 pseudo-randomly over 3 words 24'h000001, 24'h800000, 24'hFFFFFF -> a receiver model reconstructs the identical words in order; no duplicate or lost bits.
- i_en dropped at bit 10 of 24'h123456 for 5 cycles -> o_dout_valid=0 and all state frozen during the pause. The remaining 14 bits continue correctly and the word reconstructs to 24'h123456.
- FIFO full with one pop and one push on the same edge -> push refused and ov_fifo_count goes 4->3. Push into the FIFO on the same edge as a last-bit reload -> no bubble and count unchanged.
- i_rst asserted asynchronously mid-cycle at bit 7 with 3 words queued -> o_dout_valid and ov_fifo_count go to 0 immediately. After release, a new push transmits cleanly with no stale bits.
